mem_access_seq: RTL and testbench

Multicycle sequencer for the 64-bit data-memory port. The control unit hands it one load or store per request. For loads it reads the addressed doubleword and returns it sign- or zero-extended. For sub-doubleword stores it performs the read-modify-write merge into the low bits of the doubleword. This removes the per-size MDR wait and merge states from the main FSM, and the control unit only waits for `done`.

---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access_seq.sv | 72 +++++++
 tb/tb_mem_access_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: request/response and data-memory port bundle for mem_access_seq
interface mem_access_if;
   logic        req;
   logic        is_store;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [63:0] rdata;
   logic [63:0] mem_addr;
   logic        mem_wr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   modport master (
      output req, is_store, funct3, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
   );
   modport slave (
      input  req, is_store, funct3, addr, wdata, mem_rdata,
      output busy, done, err, rdata, mem_addr, mem_wr, mem_wdata
   );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle load/extend and store read-modify-write sequencer for the 64-bit data port
module mem_access_seq #(
   parameter int MEM_LAT = 1
) (
   input logic        clk,
   input logic        reset,
   mem_access_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, CAPTURE, WRITE, DONE} state_t;
   state_t      state, state_nx;
   logic [3:0]  cnt;
   logic [63:0] addr_q, wdata_q, mdr, rdata_q, ext, d;
   logic [2:0]  f3_q;
   logic        st_q, ill_q, ill_in;
   assign ill_in = bus.is_store ? bus.funct3[2] : (bus.funct3 == 3'b111);
   assign d = bus.mem_rdata;
   assign ext = f3_q == 3'b000 ? {{56{d[7]}}, d[7:0]} :
                f3_q == 3'b001 ? {{48{d[15]}}, d[15:0]} :
                f3_q == 3'b010 ? {{32{d[31]}}, d[31:0]} :
                f3_q == 3'b100 ? {56'h0, d[7:0]} :
                f3_q == 3'b101 ? {48'h0, d[15:0]} :
                f3_q == 3'b110 ? {32'h0, d[31:0]} : d;
   assign bus.mem_wdata = f3_q[1:0] == 2'b00 ? {mdr[63:8], wdata_q[7:0]} :
                          f3_q[1:0] == 2'b01 ? {mdr[63:16], wdata_q[15:0]} :
                          f3_q[1:0] == 2'b10 ? {mdr[63:32], wdata_q[31:0]} : wdata_q;
   assign bus.busy     = state != IDLE;
   assign bus.done     = state == DONE;
   assign bus.err      = state == DONE && ill_q;
   assign bus.mem_wr   = state == WRITE;
   assign bus.mem_addr = addr_q;
   assign bus.rdata    = rdata_q;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = !bus.req ? IDLE : ill_in ? DONE :
                             (bus.is_store && bus.funct3 == 3'b011) ? WRITE : RD_WAIT;
         RD_WAIT: state_nx = cnt == 4'd0 ? CAPTURE : RD_WAIT;
         CAPTURE: state_nx = st_q ? WRITE : DONE;
         WRITE:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr     <= '0;
         rdata_q <= '0;
         f3_q    <= '0;
         st_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            f3_q    <= bus.funct3;
            st_q    <= bus.is_store;
            ill_q   <= ill_in;
            cnt     <= 4'(MEM_LAT - 1);
         end else if (state == RD_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == CAPTURE) begin
            mdr <= bus.mem_rdata;
            if (!st_q) rdata_q <= ext;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed checks of mem_access_seq at MEM_LAT=1 (dut a) and MEM_LAT=3 (dut b)
module tb_mem_access_seq;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_a = 1'b0, req_b = 1'b0, is_store = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [63:0] addr = '0, wdata = '0, mem_word = '0;
   int          pass = 0, total = 0;
   mem_access_if ia ();
   mem_access_if ib ();
   assign ia.req = req_a;
   assign ib.req = req_b;
   assign ia.is_store = is_store;
   assign ib.is_store = is_store;
   assign ia.funct3 = funct3;
   assign ib.funct3 = funct3;
   assign ia.addr = addr;
   assign ib.addr = addr;
   assign ia.wdata = wdata;
   assign ib.wdata = wdata;
   assign ia.mem_rdata = mem_word;
   assign ib.mem_rdata = mem_word;
   mem_access_seq #(.MEM_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   mem_access_seq #(.MEM_LAT(3)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_access(input bit sel, input bit st, input logic [2:0] f3,
                            input logic [63:0] a, input logic [63:0] wd,
                            output int done_cyc, output bit err_seen, output int wr_cnt,
                            output int wr_cyc, output logic [63:0] wr_data,
                            output logic [63:0] rd, output logic [63:0] maddr);
      is_store = st; funct3 = f3; addr = a; wdata = wd;
      if (sel) req_b = 1'b1; else req_a = 1'b1;
      step();
      req_a = 1'b0; req_b = 1'b0;
      done_cyc = -1; err_seen = 1'b0; wr_cnt = 0; wr_cyc = -1; wr_data = '0; rd = '0; maddr = '0;
      for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
         if (sel ? ib.mem_wr : ia.mem_wr) begin
            wr_cnt++;
            wr_cyc = c;
            wr_data = sel ? ib.mem_wdata : ia.mem_wdata;
         end
         if (sel ? ib.done : ia.done) begin
            done_cyc = c;
            err_seen = sel ? ib.err : ia.err;
            rd = sel ? ib.rdata : ia.rdata;
            maddr = sel ? ib.mem_addr : ia.mem_addr;
         end
         step();
      end
   endtask

   task automatic test_reset();
      req_a = 1'b1; req_b = 1'b1;
      for (int i = 0; i < 2; i++) begin
         is_store = 1'($urandom); funct3 = 3'($urandom);
         addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
         step();
         total++;
         if ({ia.busy, ia.done, ia.err, ia.mem_wr, ib.busy, ib.done, ib.err, ib.mem_wr} !== 8'h0 ||
             ia.rdata !== 64'h0 || ia.mem_addr !== 64'h0 || ib.rdata !== 64'h0 || ib.mem_addr !== 64'h0) begin
            $display("FAIL reset_outputs cycle %0d: busy=%b done=%b err=%b wr=%b rdata=%h maddr=%h, want all 0",
                     i, ia.busy, ia.done, ia.err, ia.mem_wr, ia.rdata, ia.mem_addr);
         end else pass++;
      end
      reset = 1'b0;
      step();
      total++;
      if (ia.busy !== 1'b1 || ib.busy !== 1'b1)
         $display("FAIL reset_first_accept: busy a=%b b=%b, want 1 1", ia.busy, ib.busy);
      else pass++;
      req_a = 1'b0; req_b = 1'b0;
      for (int i = 0; i < 20 && (ia.busy || ib.busy); i++) step();
      total++;
      if (ia.busy !== 1'b0 || ib.busy !== 1'b0)
         $display("FAIL reset_drain: busy a=%b b=%b, want 0 0", ia.busy, ib.busy);
      else pass++;
   endtask

   task automatic test_loads();
      logic [2:0]  f3s [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011};
      logic [63:0] exp [7] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_8080, 64'h8080,
                              64'hFFFF_FFFF_8000_8080, 64'h8000_8080, 64'h0000_0000_8000_8080};
      int dc, wc, wy; bit e; logic [63:0] wd, rd, ma;
      mem_word = 64'h0000_0000_8000_8080;
      for (int i = 0; i < 7; i++) begin
         do_access(1'b0, 1'b0, f3s[i], 64'h1000 + 64'(i * 8), 64'h0, dc, e, wc, wy, wd, rd, ma);
         total++;
         if (rd !== exp[i] || dc !== 3 || e !== 1'b0 || wc !== 0 || ma !== 64'h1000 + 64'(i * 8))
            $display("FAIL load_f3_%b: rdata=%h done_cyc=%0d err=%b wr=%0d maddr=%h, want %h 3 0 0 %h",
                     f3s[i], rd, dc, e, wc, ma, exp[i], 64'h1000 + 64'(i * 8));
         else pass++;
      end
   endtask

   task automatic test_sub_store();
      int dc, wc, wy; bit e; logic [63:0] wd, rd, ma;
      mem_word = 64'h1122_3344_5566_7788;
      do_access(1'b1, 1'b1, 3'b001, 64'h2000, 64'hAAAA_AAAA_AAAA_BEEF, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (wc !== 1 || wy !== 5 || wd !== 64'h1122_3344_5566_BEEF || dc !== 6 || e !== 1'b0)
         $display("FAIL sh_lat3: wr_cnt=%0d wr_cyc=%0d data=%h done_cyc=%0d err=%b, want 1 5 112233445566beef 6 0",
                  wc, wy, wd, dc, e);
      else pass++;
      do_access(1'b0, 1'b1, 3'b000, 64'h2008, 64'hAAAA_AAAA_AAAA_BEEF, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (wc !== 1 || wy !== 3 || wd !== 64'h1122_3344_5566_77EF || dc !== 4)
         $display("FAIL sb_lat1: wr_cnt=%0d wr_cyc=%0d data=%h done_cyc=%0d, want 1 3 11223344556677ef 4",
                  wc, wy, wd, dc);
      else pass++;
      do_access(1'b0, 1'b1, 3'b010, 64'h2010, 64'hAAAA_AAAA_AAAA_BEEF, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (wc !== 1 || wy !== 3 || wd !== 64'h1122_3344_AAAA_BEEF || dc !== 4)
         $display("FAIL sw_lat1: wr_cnt=%0d wr_cyc=%0d data=%h done_cyc=%0d, want 1 3 11223344aaaabeef 4",
                  wc, wy, wd, dc);
      else pass++;
   endtask

   task automatic test_sd();
      int dc, wc, wy; bit e; logic [63:0] wd, rd, ma;
      for (int s = 0; s < 2; s++) begin
         do_access(1'(s), 1'b1, 3'b011, 64'h3000, 64'hDEAD_BEEF_0123_4567, dc, e, wc, wy, wd, rd, ma);
         total++;
         if (wc !== 1 || wy !== 1 || wd !== 64'hDEAD_BEEF_0123_4567 || dc !== 2 || ma !== 64'h3000)
            $display("FAIL sd_dut%0d: wr_cnt=%0d wr_cyc=%0d data=%h done_cyc=%0d maddr=%h, want 1 1 deadbeef01234567 2 3000",
                     s, wc, wy, wd, dc, ma);
         else pass++;
      end
   endtask

   task automatic test_illegal();
      int dc, wc, wy; bit e; logic [63:0] wd, rd, ma;
      mem_word = 64'h0123_4567_89AB_CDEF;
      do_access(1'b0, 1'b0, 3'b011, 64'h4000, 64'h0, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (rd !== 64'h0123_4567_89AB_CDEF)
         $display("FAIL illegal_setup_ld: rdata=%h, want 0123456789abcdef", rd);
      else pass++;
      mem_word = 64'h5555_5555_5555_5555;
      do_access(1'b0, 1'b1, 3'b100, 64'h4008, 64'hFFFF, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (dc !== 1 || e !== 1'b1 || wc !== 0 || rd !== 64'h0123_4567_89AB_CDEF)
         $display("FAIL illegal_store: done_cyc=%0d err=%b wr=%0d rdata=%h, want 1 1 0 0123456789abcdef",
                  dc, e, wc, rd);
      else pass++;
      do_access(1'b1, 1'b0, 3'b111, 64'h4010, 64'h0, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (dc !== 1 || e !== 1'b1 || wc !== 0 || rd !== 64'h0)
         $display("FAIL illegal_load_b: done_cyc=%0d err=%b wr=%0d rdata=%h, want 1 1 0 0", dc, e, wc, rd);
      else pass++;
      do_access(1'b0, 1'b0, 3'b111, 64'h4018, 64'h0, dc, e, wc, wy, wd, rd, ma);
      total++;
      if (dc !== 1 || e !== 1'b1 || wc !== 0 || rd !== 64'h0123_4567_89AB_CDEF || ia.rdata !== 64'h0123_4567_89AB_CDEF)
         $display("FAIL illegal_load_a: done_cyc=%0d err=%b wr=%0d rdata=%h, want 1 1 0 0123456789abcdef",
                  dc, e, wc, rd);
      else pass++;
   endtask

   task automatic test_back_to_back();
      int wr_seen = 0, done_seen = 0;
      int done_at [2] = '{-1, -1};
      bit busy4 = 1'b1, busy5 = 1'b0;
      is_store = 1'b1; funct3 = 3'b000; addr = 64'h5000; wdata = 64'h77;
      req_a = 1'b1;
      step();
      req_a = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      total++;
      if (ia.busy !== 1'b0 || ia.rdata !== 64'h0)
         $display("FAIL abort_state: busy=%b rdata=%h, want 0 0", ia.busy, ia.rdata);
      else pass++;
      for (int c = 0; c < 6; c++) begin
         if (ia.mem_wr) wr_seen++;
         if (ia.done) done_seen++;
         step();
      end
      total++;
      if (wr_seen !== 0 || done_seen !== 0)
         $display("FAIL abort_quiet: mem_wr cycles=%0d done cycles=%0d, want 0 0", wr_seen, done_seen);
      else pass++;
      mem_word = 64'hCAFE_F00D_1234_5678;
      is_store = 1'b0; funct3 = 3'b011; addr = 64'h6000;
      done_seen = 0;
      req_a = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (ia.done) begin
            if (done_seen < 2) done_at[done_seen] = c;
            done_seen++;
         end
         if (c == 4) busy4 = ia.busy;
         if (c == 5) begin
            busy5 = ia.busy;
            req_a = 1'b0;
         end
      end
      total++;
      if (done_seen !== 2 || done_at[0] !== 3 || done_at[1] !== 7)
         $display("FAIL held_req_dones: count=%0d first=%0d second=%0d, want 2 3 7", done_seen, done_at[0], done_at[1]);
      else pass++;
      total++;
      if (busy4 !== 1'b0 || busy5 !== 1'b1 || ia.rdata !== 64'hCAFE_F00D_1234_5678)
         $display("FAIL held_req_accept: busy4=%b busy5=%b rdata=%h, want 0 1 cafef00d12345678", busy4, busy5, ia.rdata);
      else pass++;
   endtask

   initial begin
      #1;
      test_reset();
      test_loads();
      test_sub_store();
      test_sd();
      test_illegal();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
